// File: rtl/mem_seq_if.sv
// Handshake and bus bundle between the core/memory side and mem_seq.
// master drives requests and memory responses; slave is the sequencer.
interface mem_seq_if;
    logic        fetch_en;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        mar_load;
    logic [31:0] mar_in;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] mar;
    logic        sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] mdr;
    logic        data_done;
    logic        busy;

    modport master (
        output fetch_en, pc_load, pc_in,
        output mar_load, mar_in,
        output data_req, data_we, data_wdata,
        output mem_ack, mem_rdata,
        input  pc, mar, sel,
        input  mem_req, mem_we, mem_wdata,
        input  ir, ir_valid, mdr, data_done,
        input  busy
    );

    modport slave (
        input  fetch_en, pc_load, pc_in,
        input  mar_load, mar_in,
        input  data_req, data_we, data_wdata,
        input  mem_ack, mem_rdata,
        output pc, mar, sel,
        output mem_req, mem_we, mem_wdata,
        output ir, ir_valid, mdr, data_done,
        output busy
    );
endinterface

// File: rtl/mem_seq.sv
// Memory access sequencer: arbitrates instruction fetches and data
// accesses onto one memory port via a three-state FSM.
module mem_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic     clk,
    input logic     rst_n,
    mem_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_start;
    logic [31:0] w_pc_tgt;
    logic [31:0] r_pc;
    logic [31:0] r_mar;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_ir_valid;
    logic        r_data_done;
    logic        r_redir;
    logic [31:0] r_redir_pc;

    always_comb begin
        w_next = IDLE;
        if (bus.data_req)
            w_next = DATA;
        else if (bus.fetch_en)
            w_next = FETCH;
    end

    // The start rule is re-evaluated on every ack so transactions chain.
    assign w_start = (r_state == IDLE) | bus.mem_ack;

    always_comb begin
        w_pc_tgt = r_pc + PC_STEP;
        if (bus.pc_load)
            w_pc_tgt = bus.pc_in;
        else if (r_redir)
            w_pc_tgt = r_redir_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_mar       <= 32'h0;
            r_ir        <= 32'h0;
            r_mdr       <= 32'h0;
            r_wdata     <= 32'h0;
            r_we        <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_data_done <= 1'b0;
            r_redir     <= 1'b0;
            r_redir_pc  <= 32'h0;
        end else begin
            r_ir_valid  <= 1'b0;
            r_data_done <= 1'b0;
            if (w_start) begin
                r_state <= w_next;
                if (w_next == DATA) begin
                    r_we    <= bus.data_we;
                    r_wdata <= bus.data_wdata;
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (bus.mar_load)
                        r_mar <= bus.mar_in;
                    if (bus.pc_load)
                        r_pc <= bus.pc_in;
                end
                FETCH: begin
                    if (bus.mar_load)
                        r_mar <= bus.mar_in;
                    if (bus.mem_ack) begin
                        r_ir       <= bus.mem_rdata;
                        r_ir_valid <= 1'b1;
                        r_pc       <= w_pc_tgt;
                        r_redir    <= 1'b0;
                    end else if (bus.pc_load) begin
                        r_redir    <= 1'b1;
                        r_redir_pc <= bus.pc_in;
                    end
                end
                DATA: begin
                    if (bus.pc_load)
                        r_pc <= bus.pc_in;
                    if (bus.mem_ack) begin
                        r_data_done <= 1'b1;
                        if (!r_we)
                            r_mdr <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = (r_state != IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sel       = (r_state == DATA);
    assign bus.mem_we    = (r_state == DATA) & r_we;
    assign bus.mem_wdata = r_wdata;
    assign bus.pc        = r_pc;
    assign bus.mar       = r_mar;
    assign bus.ir        = r_ir;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.mdr       = r_mdr;
    assign bus.data_done = r_data_done;
endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: a transaction-level model predicts each
// completed fetch/data access; a monitor pops and compares on the pulses.
module tb_mem_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errs;

    typedef struct {
        bit          is_data;
        logic [31:0] val;
        logic [31:0] pc;
        logic [31:0] mar;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_mar;
    logic [31:0] m_mdr;

    mem_seq_if bus ();

    mem_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push(input bit d, input logic [31:0] v);
        exp_t e;
        e.is_data = d;
        e.val     = v;
        e.pc      = m_pc;
        e.mar     = m_mar;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.ir_valid || bus.data_done)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("kind", {31'b0, bus.data_done},
                    {31'b0, e.is_data});
                if (e.is_data) begin
                    chk("mdr", bus.mdr, e.val);
                    chk("mar", bus.mar, e.mar);
                end else begin
                    chk("ir", bus.ir, e.val);
                    chk("pc", bus.pc, e.pc);
                end
            end
        end
    end

    task automatic clr();
        bus.fetch_en   = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_in      = 32'h0;
        bus.mar_load   = 1'b0;
        bus.mar_in     = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_wdata = 32'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_sel", {31'b0, bus.sel}, 32'd0);
        chk("rst_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_irv", {31'b0, bus.ir_valid}, 32'd0);
        chk("rst_done", {31'b0, bus.data_done}, 32'd0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_mar", bus.mar, 32'h0);
        chk("rst_ir", bus.ir, 32'h0);
        chk("rst_mdr", bus.mdr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
    endtask

    // Called at a negedge with the FSM idle; returns one negedge after ack.
    task automatic fetch(input int dly, input bit redir, input int rpos,
                         input logic [31:0] tgt,
                         input logic [31:0] rd);
        logic [31:0] old;
        old = m_pc;
        bus.fetch_en = 1'b1;
        @(negedge clk);
        bus.fetch_en = 1'b0;
        chk("f_req", {31'b0, bus.mem_req}, 32'd1);
        chk("f_sel", {31'b0, bus.sel}, 32'd0);
        chk("f_pc", bus.pc, old);
        for (int i = 0; i < dly; i++) begin
            bus.pc_load = redir && (i == rpos);
            bus.pc_in   = tgt;
            @(negedge clk);
            bus.pc_load = 1'b0;
            chk("f_pc_hold", bus.pc, old);
            chk("f_req_hold", {31'b0, bus.mem_req}, 32'd1);
        end
        m_pc = redir ? tgt : old + 32'd4;
        push(1'b0, rd);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic data(input bit we, input bit ml,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] rd, input int dly);
        bus.mar_load   = ml;
        bus.mar_in     = addr;
        bus.data_req   = 1'b1;
        bus.data_we    = we;
        bus.data_wdata = wd;
        if (ml)
            m_mar = addr;
        @(negedge clk);
        bus.mar_load   = 1'b0;
        bus.data_req   = 1'b0;
        bus.data_we    = ~we;
        bus.data_wdata = ~wd;
        chk("d_req", {31'b0, bus.mem_req}, 32'd1);
        chk("d_sel", {31'b0, bus.sel}, 32'd1);
        chk("d_we", {31'b0, bus.mem_we}, {31'b0, we});
        chk("d_wdata", bus.mem_wdata, wd);
        chk("d_mar", bus.mar, m_mar);
        for (int i = 0; i < dly; i++) begin
            bus.mar_load = 1'($urandom_range(0, 1));
            bus.mar_in   = $urandom;
            @(negedge clk);
            bus.mar_load = 1'b0;
            chk("d_mar_hold", bus.mar, m_mar);
            chk("d_wdata_hold", bus.mem_wdata, wd);
            chk("d_we_hold", {31'b0, bus.mem_we}, {31'b0, we});
        end
        if (!we)
            m_mdr = rd;
        push(1'b1, m_mdr);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0;
        errs   = 0;
        m_pc   = 32'h0;
        m_mar  = 32'h0;
        m_mdr  = 32'h0;
        clr();
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming fetches with ack held high.
        n = 0;
        for (int k = 0; k < 5; k++) begin
            m_pc = m_pc + 32'd4;
            push(1'b0, 32'hA5A5_0001);
        end
        bus.fetch_en  = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hA5A5_0001;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            chk("s_sel", {31'b0, bus.sel}, 32'd0);
            if (bus.ir_valid)
                n++;
        end
        bus.fetch_en = 1'b0;
        if (n < 4)
            chk("stream_timeout", n, 4);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);

        // pc wrap
        bus.pc_load = 1'b1;
        bus.pc_in   = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.pc_load = 1'b0;
        m_pc = 32'hFFFF_FFFC;
        chk("pc_load_idle", bus.pc, m_pc);
        fetch(0, 1'b0, 0, 32'h0, 32'h1234_5678);
        chk("pc_wrap", bus.pc, 32'h0);

        // Redirect during fetch, ack three cycles later.
        fetch(3, 1'b1, 0, 32'h100, 32'h0BAD_F00D);
        chk("redirect_pc", bus.pc, 32'h100);

        // mar_load + data_req read in one idle cycle.
        data(1'b0, 1'b1, 32'h2000, 32'h0, 32'hDEAD_BEEF, 0);
        chk("rd_mdr", bus.mdr, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("done_once", {31'b0, bus.data_done}, 32'd0);

        // Data wins over fetch; fetch chains on the data ack.
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b0;
        bus.fetch_en   = 1'b1;
        @(negedge clk);
        bus.data_req = 1'b0;
        chk("prio_sel", {31'b0, bus.sel}, 32'd1);
        m_mdr = 32'h5555_AAAA;
        push(1'b1, m_mdr);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.fetch_en = 1'b0;
        chk("chain_req", {31'b0, bus.mem_req}, 32'd1);
        chk("chain_sel", {31'b0, bus.sel}, 32'd0);
        m_pc = m_pc + 32'd4;
        push(1'b0, 32'h7777_0000);
        bus.mem_rdata = 32'h7777_0000;
        @(negedge clk);
        bus.mem_ack = 1'b0;

        // Randomized mix.
        for (int t = 0; t < 40; t++) begin
            int op;
            int dly;
            op  = $urandom_range(0, 1);
            dly = $urandom_range(0, 3);
            if (op == 0) begin
                bit r;
                r = (dly > 0) && ($urandom_range(0, 1) == 1);
                fetch(dly, r,
                      (dly > 0) ? $urandom_range(0, dly - 1) : 0,
                      $urandom & 32'hFFFF_FFFC, $urandom);
            end else begin
                data(1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     $urandom, $urandom, $urandom, dly);
            end
        end

        // Reset mid data write; a late ack must be ignored.
        bus.mar_load   = 1'b1;
        bus.mar_in     = 32'h3000;
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_wdata = 32'hCAFE_0001;
        @(negedge clk);
        clr();
        chk("pre_rst_req", {31'b0, bus.mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        m_pc  = 32'h0;
        m_mar = 32'h0;
        m_mdr = 32'h0;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late_ack_req", {31'b0, bus.mem_req}, 32'd0);
        chk("late_ack_done", {31'b0, bus.data_done}, 32'd0);
        chk("late_ack_mdr", bus.mdr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
